// File: rtl/input_debouncer.sv
// input_debouncer
// Conditions a raw, asynchronous, possibly bouncing input. The input is
// brought into the clock domain with a 2-flop synchronizer. A change then has
// to hold for STABLE_CYCLES+1 consecutive sampled edges before the registered
// clean level Y follows it. One-cycle rise/fall pulses mark each change of Y.
// Every output comes straight from a flop, so nothing reaches Y combinationally
// from A_raw.

module input_debouncer #(
    parameter int STABLE_CYCLES = 1000,
    parameter int CNT_W         = 10
) (
    input  logic clk,
    input  logic rst_n,
    input  logic A_raw,
    input  logic en,
    output logic Y,
    output logic rise,
    output logic fall,
    output logic busy
);

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        QUAL = 1'b1
    } state_t;

    localparam logic [CNT_W-1:0] CNT_ZERO   = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);
    localparam logic [CNT_W-1:0] STABLE_CNT = CNT_W'(STABLE_CYCLES);

    logic             sync1_r;
    logic             sync2_r;
    state_t           state_r;
    state_t           next_state_s;
    logic [CNT_W-1:0] cnt_r;
    logic [CNT_W-1:0] cnt_next_s;
    logic             y_r;
    logic             y_next_s;
    logic             rise_r;
    logic             rise_next_s;
    logic             fall_r;
    logic             fall_next_s;
    logic             busy_r;

    // Two-flop synchronizer for the raw input; it runs regardless of en.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_r <= 1'b0;
            sync2_r <= 1'b0;
        end else begin
            sync1_r <= A_raw;
            sync2_r <= sync1_r;
        end
    end

    // State, qualification counter and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= IDLE;
            cnt_r   <= CNT_ZERO;
            y_r     <= 1'b0;
            rise_r  <= 1'b0;
            fall_r  <= 1'b0;
            busy_r  <= 1'b0;
        end else begin
            state_r <= next_state_s;
            cnt_r   <= cnt_next_s;
            y_r     <= y_next_s;
            rise_r  <= rise_next_s;
            fall_r  <= fall_next_s;
            busy_r  <= (next_state_s == QUAL);
        end
    end

    // Next-state logic. Any bounce back to Y, or en dropping, abandons the
    // qualification, so a later attempt must start again from one.
    always_comb begin
        next_state_s = state_r;
        cnt_next_s   = cnt_r;
        y_next_s     = y_r;
        rise_next_s  = 1'b0;
        fall_next_s  = 1'b0;
        case (state_r)
            IDLE: begin
                if (en && (sync2_r != y_r)) begin
                    next_state_s = QUAL;
                    cnt_next_s   = CNT_ONE;
                end else begin
                    next_state_s = IDLE;
                    cnt_next_s   = CNT_ZERO;
                end
            end
            QUAL: begin
                if (!en) begin
                    next_state_s = IDLE;
                    cnt_next_s   = CNT_ZERO;
                end else if (sync2_r == y_r) begin
                    next_state_s = IDLE;
                    cnt_next_s   = CNT_ZERO;
                end else if (cnt_r == STABLE_CNT) begin
                    next_state_s = IDLE;
                    cnt_next_s   = CNT_ZERO;
                    y_next_s     = sync2_r;
                    rise_next_s  = sync2_r;
                    fall_next_s  = ~sync2_r;
                end else begin
                    next_state_s = QUAL;
                    cnt_next_s   = cnt_r + CNT_ONE;
                end
            end
            default: begin
                next_state_s = IDLE;
                cnt_next_s   = CNT_ZERO;
            end
        endcase
    end

    assign Y    = y_r;
    assign rise = rise_r;
    assign fall = fall_r;
    assign busy = busy_r;

endmodule

// File: tb/tb_input_debouncer.sv
// Testbench for input_debouncer with STABLE_CYCLES=4 and a 10 ns clock.
// A run-length reference model predicts Y/rise/fall/busy each cycle.
// Directed scenarios also carry hand-computed literal checkpoints.

module tb_input_debouncer;

    localparam int S = 4;

    logic clk;
    logic rst_n;
    logic A_raw;
    logic en;
    logic Y;
    logic rise;
    logic fall;
    logic busy;

    int vectors     = 0;
    int miscompares = 0;

    input_debouncer #(.STABLE_CYCLES(S), .CNT_W(3)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .A_raw (A_raw),
        .en    (en),
        .Y     (Y),
        .rise  (rise),
        .fall  (fall),
        .busy  (busy)
    );

    // 10 ns clock: rising edges at 5, 15, 25 ...; inputs change on falling edges.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Reference model. The level seen by the qualifier at an edge is A_raw
    // as sampled two edges earlier. Y flips once that level has differed from
    // Y, with en high, on S+1 consecutive edges.
    logic m_y    = 1'b0;
    logic m_rise = 1'b0;
    logic m_fall = 1'b0;
    logic m_busy = 1'b0;
    int   run    = 0;
    logic hist[$];

    initial begin
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) begin
                hist.delete();
                run    = 0;
                m_y    = 1'b0;
                m_rise = 1'b0;
                m_fall = 1'b0;
                m_busy = 1'b0;
            end else begin
                logic seen;
                seen = (hist.size() >= 2) ? hist[hist.size()-2] : 1'b0;
                hist.push_back(A_raw);
                if (hist.size() > 4) void'(hist.pop_front());
                m_rise = 1'b0;
                m_fall = 1'b0;
                if (en && (seen != m_y)) begin
                    run = run + 1;
                    if (run == S + 1) begin
                        m_y    = seen;
                        m_rise = seen;
                        m_fall = ~seen;
                        run    = 0;
                    end
                end else begin
                    run = 0;
                end
                m_busy = (run > 0);
            end
        end
    end

    task automatic chk(input string name, input logic act, input logic exp);
        vectors = vectors + 1;
        if (act !== exp) begin
            miscompares = miscompares + 1;
            $display("FAIL %s t=%0t actual=%b required=%b", name, $time, act, exp);
        end
    endtask

    // Compare the DUT against the model once per cycle, midway between edges.
    initial begin
        forever begin
            @(negedge clk);
            chk("model_Y", Y, m_y);
            chk("model_rise", rise, m_rise);
            chk("model_fall", fall, m_fall);
            chk("model_busy", busy, m_busy);
            chk("rise_fall_exclusive", rise & fall, 1'b0);
        end
    end

    // Log each change on the debounced level and the pulses.
    initial begin
        forever begin
            @(Y or rise or fall);
            $display("t=%0t Y=%b rise=%b fall=%b", $time, Y, rise, fall);
        end
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    initial begin
        rst_n = 1'b0;
        A_raw = 1'b1;
        en    = 1'b1;

        // 1: reset with A_raw=1, then release and qualify the rising level.
        tick(2);
        chk("rst_Y", Y, 1'b0);
        chk("rst_rise", rise, 1'b0);
        chk("rst_fall", fall, 1'b0);
        chk("rst_busy", busy, 1'b0);
        rst_n = 1'b1;
        tick(6);
        chk("t1_Y_before", Y, 1'b0);
        chk("t1_busy", busy, 1'b1);
        tick(1);
        chk("t1_Y_after", Y, 1'b1);
        chk("t1_rise", rise, 1'b1);
        chk("t1_busy_done", busy, 1'b0);
        tick(1);
        chk("t1_rise_once", rise, 1'b0);
        chk("t1_Y_hold", Y, 1'b1);

        // 2: clean fall.
        A_raw = 1'b0;
        tick(2);
        chk("t2_busy_early", busy, 1'b0);
        tick(1);
        chk("t2_busy", busy, 1'b1);
        tick(3);
        chk("t2_Y_before", Y, 1'b1);
        tick(1);
        chk("t2_Y_after", Y, 1'b0);
        chk("t2_fall", fall, 1'b1);
        chk("t2_rise", rise, 1'b0);
        tick(1);
        chk("t2_fall_once", fall, 1'b0);

        // 3: bounce 1,0,1,0 every 20 ns, then hold 1.
        A_raw = 1'b1; tick(2);
        A_raw = 1'b0; tick(2);
        A_raw = 1'b1; tick(2);
        A_raw = 1'b0; tick(2);
        chk("t3_Y_during_bounce", Y, 1'b0);
        A_raw = 1'b1;
        tick(6);
        chk("t3_Y_before", Y, 1'b0);
        tick(1);
        chk("t3_Y_after", Y, 1'b1);
        chk("t3_rise", rise, 1'b1);
        tick(2);

        // 4: bring Y back to 0, then a 30 ns glitch.
        A_raw = 1'b0;
        tick(10);
        chk("t4_Y_low", Y, 1'b0);
        A_raw = 1'b1; tick(3);
        A_raw = 1'b0; tick(8);
        chk("t4_Y_glitch", Y, 1'b0);
        chk("t4_busy_idle", busy, 1'b0);

        // 5: en dropped after three qualifying cycles, then re-enabled.
        A_raw = 1'b1;
        tick(5);
        chk("t5_busy", busy, 1'b1);
        en = 1'b0;
        tick(1);
        chk("t5_busy_abort", busy, 1'b0);
        chk("t5_Y_abort", Y, 1'b0);
        tick(3);
        chk("t5_Y_frozen", Y, 1'b0);
        en = 1'b1;
        tick(4);
        chk("t5_Y_before", Y, 1'b0);
        chk("t5_busy_requal", busy, 1'b1);
        tick(1);
        chk("t5_Y_after", Y, 1'b1);
        chk("t5_rise", rise, 1'b1);
        tick(1);

        // 6: short async reset while qualifying a fall with Y=1.
        A_raw = 1'b0;
        tick(4);
        chk("t6_busy_pre", busy, 1'b1);
        chk("t6_Y_pre", Y, 1'b1);
        #1 rst_n = 1'b0;
        #1;
        chk("t6_Y_async", Y, 1'b0);
        chk("t6_busy_async", busy, 1'b0);
        chk("t6_rise_async", rise, 1'b0);
        chk("t6_fall_async", fall, 1'b0);
        #2 rst_n = 1'b1;
        tick(10);
        chk("t6_Y_stays", Y, 1'b0);
        A_raw = 1'b1;
        tick(10);
        chk("t6_Y_recover", Y, 1'b1);
        tick(2);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
